// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch looks up combinationally with the current PC; the MEM stage writes
// back each resolved conditional branch. Two saturating performance counters
// track resolved branches and mispredictions.
module branch_predictor #(
  parameter int ENTRIES = 8,
  localparam int IDXW = $clog2(ENTRIES)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [31:0]     pc,
  output logic            predict,
  output logic [IDXW-1:0] index,
  output logic [31:0]     br_target,
  input  logic            upd_en,
  input  logic [IDXW-1:0] upd_index,
  input  logic [31:0]     upd_pc_plus4,
  input  logic            upd_taken,
  input  logic [31:0]     upd_target,
  input  logic            upd_predict,
  output logic [31:0]     br_count,
  output logic [31:0]     miss_count
);

  localparam int TAGW = 30 - IDXW;

  // Direction counter encodings: strongly/weakly not-taken, weakly/strongly taken.
  typedef enum logic [1:0] {
    CTR_SN = 2'b00,
    CTR_WN = 2'b01,
    CTR_WT = 2'b10,
    CTR_ST = 2'b11
  } ctr_e;

  // Per-entry storage.
  logic            valid_r  [ENTRIES];
  logic [TAGW-1:0] tag_r    [ENTRIES];
  logic [31:0]     target_r [ENTRIES];
  ctr_e            ctr_r    [ENTRIES];

  logic [31:0]     br_count_r;
  logic [31:0]     miss_count_r;

  // Lookup side.
  logic [IDXW-1:0] idx_s;
  logic [TAGW-1:0] ptag_s;
  logic            hit_s;
  logic            predict_s;
  logic [31:0]     br_target_s;

  // Update side.
  logic [31:0]     bpc_s;
  logic [TAGW-1:0] utag_s;
  logic            upd_hit_s;
  logic            unused_s;

  // Next counter state for one resolved outcome, saturating at both ends.
  function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
    ctr_e nxt;
    case (cur)
      CTR_SN:  nxt = taken ? CTR_WN : CTR_SN;
      CTR_WN:  nxt = taken ? CTR_WT : CTR_SN;
      CTR_WT:  nxt = taken ? CTR_ST : CTR_WN;
      CTR_ST:  nxt = taken ? CTR_ST : CTR_WT;
      default: nxt = CTR_WN;
    endcase
    return nxt;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cur);
    logic [31:0] nxt;
    if (cur == 32'hFFFF_FFFF) begin
      nxt = cur;
    end else begin
      nxt = cur + 32'd1;
    end
    return nxt;
  endfunction

  assign idx_s     = pc[IDXW+1:2];
  assign ptag_s    = pc[31:IDXW+2];
  // The branch PC is recovered from pc_plus4; the subtraction wraps by design.
  assign bpc_s     = upd_pc_plus4 - 32'd4;
  assign utag_s    = bpc_s[31:IDXW+2];
  // upd_index is trusted, so the index bits of bpc are not compared.
  assign unused_s  = ^{pc[1:0], bpc_s[IDXW+1:0]};
  assign upd_hit_s = valid_r[upd_index] && (tag_r[upd_index] == utag_s);

  // Combinational lookup from the stored (pre-update) state; no bypass.
  always_comb begin
    hit_s       = 1'b0;
    predict_s   = 1'b0;
    br_target_s = 32'd0;
    hit_s       = valid_r[idx_s] && (tag_r[idx_s] == ptag_s);
    if (hit_s && ctr_r[idx_s][1]) begin
      predict_s   = 1'b1;
      br_target_s = target_r[idx_s];
    end else begin
      predict_s   = 1'b0;
      br_target_s = 32'd0;
    end
  end

  // Table write-back: train a hitting entry, otherwise allocate/replace it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= CTR_WN;
      end
    end else if (upd_en) begin
      if (upd_hit_s) begin
        ctr_r[upd_index] <= ctr_step(ctr_r[upd_index], upd_taken);
        if (upd_taken) begin
          target_r[upd_index] <= upd_target;
        end else begin
          target_r[upd_index] <= target_r[upd_index];
        end
      end else begin
        valid_r[upd_index]  <= 1'b1;
        tag_r[upd_index]    <= utag_s;
        target_r[upd_index] <= upd_target;
        ctr_r[upd_index]    <= upd_taken ? CTR_WT : CTR_WN;
      end
    end else begin
      valid_r  <= valid_r;
    end
  end

  // Saturating counts of resolved branches and mispredictions.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_count_r   <= 32'd0;
      miss_count_r <= 32'd0;
    end else if (upd_en) begin
      br_count_r <= sat_inc(br_count_r);
      if (upd_predict != upd_taken) begin
        miss_count_r <= sat_inc(miss_count_r);
      end else begin
        miss_count_r <= miss_count_r;
      end
    end else begin
      br_count_r   <= br_count_r;
      miss_count_r <= miss_count_r;
    end
  end

  assign predict    = predict_s;
  assign br_target  = br_target_s;
  assign index      = idx_s;
  assign br_count   = br_count_r;
  assign miss_count = miss_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor: each vector drives one
// cycle of lookup/update inputs and checks the outputs seen before the edge.
module tb_branch_predictor;

  logic        CLK;
  logic        nRST;
  logic [31:0] pc;
  logic        predict;
  logic [2:0]  index;
  logic [31:0] br_target;
  logic        upd_en;
  logic [2:0]  upd_index;
  logic [31:0] upd_pc_plus4;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_predict;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [31:0] pc;
    logic        en;
    logic [2:0]  uidx;
    logic [31:0] upc4;
    logic        utaken;
    logic [31:0] utgt;
    logic        upred;
    logic        e_pred;
    logic [31:0] e_tgt;
    logic [2:0]  e_idx;
    logic [31:0] e_br;
    logic [31:0] e_miss;
  } vec_t;

  vec_t vecs[$];

  branch_predictor #(.ENTRIES(8)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .pc           (pc),
    .predict      (predict),
    .index        (index),
    .br_target    (br_target),
    .upd_en       (upd_en),
    .upd_index    (upd_index),
    .upd_pc_plus4 (upd_pc_plus4),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_predict  (upd_predict),
    .br_count     (br_count),
    .miss_count   (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] p, input logic en, input logic [2:0] ui,
                     input logic [31:0] up4, input logic ut, input logic [31:0] utg,
                     input logic upr, input logic ep, input logic [31:0] et,
                     input logic [2:0] ei, input logic [31:0] eb, input logic [31:0] em);
    vec_t v;
    v.pc = p; v.en = en; v.uidx = ui; v.upc4 = up4; v.utaken = ut; v.utgt = utg;
    v.upred = upr; v.e_pred = ep; v.e_tgt = et; v.e_idx = ei; v.e_br = eb; v.e_miss = em;
    vecs.push_back(v);
  endtask

  task automatic drive_upd(input logic en, input logic [2:0] ui, input logic [31:0] up4,
                           input logic ut, input logic [31:0] utg, input logic upr);
    upd_en = en; upd_index = ui; upd_pc_plus4 = up4;
    upd_taken = ut; upd_target = utg; upd_predict = upr;
  endtask

  task automatic check_outs(input string tag, input logic ep, input logic [31:0] et,
                            input logic [2:0] ei, input logic [31:0] eb, input logic [31:0] em);
    check({tag, ".predict"},    {31'd0, predict}, {31'd0, ep});
    check({tag, ".br_target"},  br_target, et);
    check({tag, ".index"},      {29'd0, index}, {29'd0, ei});
    check({tag, ".br_count"},   br_count, eb);
    check({tag, ".miss_count"}, miss_count, em);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    nRST = 1'b1;
    pc   = 32'h0000_0040;
    drive_upd(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    // Reset state while nRST held low.
    #1 nRST = 1'b0;
    #2;
    check_outs("reset", 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);

    // An update pulse while in reset is dropped.
    upd_en = 1'b1;
    @(posedge CLK); #1;
    upd_en = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    check_outs("reset_drop", 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    @(posedge CLK); #1;

    //   pc            en  idx  pc_plus4      tk  target        pr  e_pred e_tgt        e_idx e_br e_miss
    // Allocate taken, then saturate to ST and decay back to WN.
    add(32'h0000_0040, 1, 3'd0, 32'h0000_0044, 1, 32'h0000_0100, 0, 0, 32'h0,         3'd0, 0,  0);
    add(32'h0000_0040, 1, 3'd0, 32'h0000_0044, 1, 32'h0000_0100, 1, 1, 32'h0000_0100, 3'd0, 1,  1);
    add(32'h0000_0040, 1, 3'd0, 32'h0000_0044, 1, 32'h0000_0100, 1, 1, 32'h0000_0100, 3'd0, 2,  1);
    add(32'h0000_0040, 1, 3'd0, 32'h0000_0044, 1, 32'h0000_0100, 1, 1, 32'h0000_0100, 3'd0, 3,  1);
    add(32'h0000_0040, 1, 3'd0, 32'h0000_0044, 0, 32'h0000_0999, 1, 1, 32'h0000_0100, 3'd0, 4,  1);
    add(32'h0000_0040, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1, 32'h0000_0100, 3'd0, 5,  2);
    add(32'h0000_0040, 1, 3'd0, 32'h0000_0044, 0, 32'h0000_0999, 1, 1, 32'h0000_0100, 3'd0, 5,  2);
    add(32'h0000_0040, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'h0,         3'd0, 6,  3);
    // Aliasing branch at 0x60 replaces entry 0 as WN.
    add(32'h0000_0040, 1, 3'd0, 32'h0000_0064, 0, 32'h0000_0200, 0, 0, 32'h0,         3'd0, 6,  3);
    add(32'h0000_0040, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'h0,         3'd0, 7,  3);
    add(32'h0000_0060, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'h0,         3'd0, 7,  3);
    // Same-cycle lookup and update: pre-update state seen, new state next cycle.
    add(32'h0000_0060, 1, 3'd0, 32'h0000_0064, 1, 32'h0000_0200, 0, 0, 32'h0,         3'd0, 7,  3);
    add(32'h0000_0060, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1, 32'h0000_0200, 3'd0, 8,  4);
    add(32'h0000_0040, 1, 3'd0, 32'h0000_0044, 1, 32'h0000_0100, 0, 0, 32'h0,         3'd0, 8,  4);
    add(32'h0000_0040, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1, 32'h0000_0100, 3'd0, 9,  5);
    // Index 7: not-taken allocate, then wrap of pc_plus4 to 0 (bpc = 0xFFFFFFFC).
    add(32'h0000_001C, 1, 3'd7, 32'h0000_0020, 0, 32'h0000_0300, 1, 0, 32'h0,         3'd7, 9,  5);
    add(32'h0000_001C, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'h0,         3'd7, 10, 6);
    add(32'hFFFF_FFFC, 1, 3'd7, 32'h0000_0000, 1, 32'h0000_0400, 0, 0, 32'h0,         3'd7, 10, 6);
    add(32'hFFFF_FFFC, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1, 32'h0000_0400, 3'd7, 11, 7);
    add(32'h0000_001C, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'h0,         3'd7, 11, 7);
    // upd_en low with other update inputs active: nothing changes.
    add(32'h0000_0040, 0, 3'd0, 32'h0000_0044, 0, 32'h0000_0777, 1, 1, 32'h0000_0100, 3'd0, 11, 7);
    add(32'h0000_0040, 0, 3'd0, 32'h0000_0000, 0, 32'h0000_0000, 0, 1, 32'h0000_0100, 3'd0, 11, 7);

    foreach (vecs[i]) begin
      pc = vecs[i].pc;
      drive_upd(vecs[i].en, vecs[i].uidx, vecs[i].upc4, vecs[i].utaken, vecs[i].utgt, vecs[i].upred);
      @(negedge CLK);
      check_outs($sformatf("vec%0d", i), vecs[i].e_pred, vecs[i].e_tgt, vecs[i].e_idx,
                 vecs[i].e_br, vecs[i].e_miss);
      @(posedge CLK); #1;
    end

    // Counter saturation: preload near the top, then two mispredicted updates.
    pc = 32'h0000_0040;
    drive_upd(1'b1, 3'd0, 32'h0000_0044, 1'b1, 32'h0000_0100, 1'b0);
    @(negedge CLK);
    force dut.br_count_r   = 32'hFFFF_FFFE;
    force dut.miss_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.br_count_r;
    release dut.miss_count_r;
    @(posedge CLK); #1;
    check("sat1.br_count",   br_count,   32'hFFFF_FFFF);
    check("sat1.miss_count", miss_count, 32'hFFFF_FFFF);
    @(posedge CLK); #1;
    upd_en = 1'b0;
    check("sat2.br_count",   br_count,   32'hFFFF_FFFF);
    check("sat2.miss_count", miss_count, 32'hFFFF_FFFF);
    check("sat2.predict",    {31'd0, predict}, 32'd1);

    // Mid-cycle asynchronous reset: no clock edge needed.
    #2 nRST = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check_outs("post_rst", 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
